fp_mul_normalize: RTL and testbench

Post-multiply normalise/round/pack stage for the single-precision FP multiplier datapath.
- Consumes the raw multiply terms from the upstream significand multiplier: sign, unnormalised biased exponent and 48-bit significand product.
- Produces a packed IEEE-754 binary32 result with round-to-nearest-even, overflow (to infinity) and underflow (flush-to-zero) flags.
- Multi-cycle FSM with a start/done handshake matching the multiplier's mul_start/mul_done style.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_round_rne.sv | 25 ++
 rtl/fp_mul_normalize.sv | 116 +++++++++++
 tb/tb_fp_mul_normalize.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: field widths, bias, special encodings,
// the packed binary32 layout and the normaliser FSM state encoding.
package fp_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 23;
  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_INF = 8'hFF;

  // Internal exponent is 11-bit signed so back-to-back increments from the
  // largest raw exponent (383) never wrap.
  localparam int          IEXP_W  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    PACK  = 2'd3
  } norm_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit significand with guard and sticky bits.
// On carry-out the significand renormalises to 1.0 (24'h800000) and the
// caller bumps the exponent.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MAN_W:0] sig_in,
  input  logic           guard,
  input  logic           sticky,
  output logic [MAN_W:0] sig_out,
  output logic           carry
);

  logic            inc;
  logic [MAN_W+1:0] sum;

  // Round up only above the halfway point, or exactly at it when odd.
  always_comb begin
    inc     = guard & (sticky | sig_in[0]);
    sum     = {1'b0, sig_in} + {{(MAN_W+1){1'b0}}, inc};
    carry   = sum[MAN_W+1];
    sig_out = carry ? {1'b1, {MAN_W{1'b0}}} : sum[MAN_W:0];
  end

endmodule

// File: rtl/fp_mul_normalize.sv
// Post-multiply normalise / round / pack stage of the binary32 multiplier.
// Four-state FSM: IDLE captures raw terms, NORM picks the significand window,
// ROUND applies RNE, PACK selects zero / inf / flush / normal encodings.
module fp_mul_normalize
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        norm_start,
  input  logic        raw_sign,
  input  logic [9:0]  raw_exp,
  input  logic [47:0] raw_mant,
  output logic        norm_busy,
  output logic [31:0] norm_result,
  output logic        norm_done,
  output logic        norm_overflow,
  output logic        norm_underflow
);

  norm_state_t              state;
  logic                     sign_q;
  logic signed [IEXP_W-1:0] exp_q;
  logic [47:0]              mant_q;
  logic [MAN_W:0]           sig_q;
  logic                     guard_q;
  logic                     sticky_q;
  logic                     zero_q;

  logic [MAN_W:0]           sig_rnd;
  logic                     rnd_carry;
  fp32_t                    pack_val;

  fp_round_rne u_rnd (
    .sig_in  (sig_q),
    .guard   (guard_q),
    .sticky  (sticky_q),
    .sig_out (sig_rnd),
    .carry   (rnd_carry)
  );

  assign norm_busy = (state != IDLE);

  // Encoding chosen in PACK: zero beats overflow beats underflow beats normal.
  always_comb begin
    pack_val = '0;
    pack_val.sign = sign_q;
    if (zero_q) begin
      pack_val.exp  = '0;
    end else if (exp_q >= 11'sd255) begin
      pack_val.exp  = EXP_INF;
    end else if (exp_q <= 11'sd0) begin
      pack_val.exp  = '0;
    end else begin
      pack_val.exp  = exp_q[EXP_W-1:0];
      pack_val.frac = sig_q[MAN_W-1:0];
    end
  end

  // FSM and datapath registers; done is a single-cycle pulse out of PACK.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      sign_q         <= 1'b0;
      exp_q          <= '0;
      mant_q         <= '0;
      sig_q          <= '0;
      guard_q        <= 1'b0;
      sticky_q       <= 1'b0;
      zero_q         <= 1'b0;
      norm_result    <= '0;
      norm_done      <= 1'b0;
      norm_overflow  <= 1'b0;
      norm_underflow <= 1'b0;
    end else begin
      norm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (norm_start) begin
            sign_q <= raw_sign;
            exp_q  <= {raw_exp[9], raw_exp};
            mant_q <= raw_mant;
            state  <= NORM;
          end
        end
        NORM: begin
          if (mant_q[47]) begin
            sig_q    <= mant_q[47:24];
            guard_q  <= mant_q[23];
            sticky_q <= |mant_q[22:0];
            exp_q    <= exp_q + 11'sd1;
          end else begin
            sig_q    <= mant_q[46:23];
            guard_q  <= mant_q[22];
            sticky_q <= |mant_q[21:0];
          end
          zero_q <= (mant_q[47:46] == 2'b00);
          state  <= ROUND;
        end
        ROUND: begin
          sig_q <= sig_rnd;
          if (rnd_carry) exp_q <= exp_q + 11'sd1;
          state <= PACK;
        end
        PACK: begin
          norm_result    <= pack_val;
          norm_overflow  <= !zero_q && (exp_q >= 11'sd255);
          norm_underflow <= !zero_q && (exp_q < 11'sd255) && (exp_q <= 11'sd0);
          norm_done      <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Directed bench for fp_mul_normalize: hand-computed binary32 results,
// latency, handshake and mid-operation reset.
module tb_fp_mul_normalize;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        norm_start = 1'b0;
  logic        raw_sign = 1'b0;
  logic [9:0]  raw_exp = '0;
  logic [47:0] raw_mant = '0;
  logic        norm_busy;
  logic [31:0] norm_result;
  logic        norm_done;
  logic        norm_overflow;
  logic        norm_underflow;

  int vectors = 0;
  int miscompares = 0;

  fp_mul_normalize dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .norm_start     (norm_start),
    .raw_sign       (raw_sign),
    .raw_exp        (raw_exp),
    .raw_mant       (raw_mant),
    .norm_busy      (norm_busy),
    .norm_result    (norm_result),
    .norm_done      (norm_done),
    .norm_overflow  (norm_overflow),
    .norm_underflow (norm_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start at a negedge, count edges to done, then check result and flags.
  task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                        input logic [47:0] m, input logic [31:0] res,
                        input logic ov, input logic un);
    int lat;
    @(negedge clk);
    raw_sign = s; raw_exp = e; raw_mant = m; norm_start = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    norm_start = 1'b0;
    raw_sign = ~s; raw_exp = ~e; raw_mant = ~m;
    check({tag, ".busy"}, {31'b0, norm_busy}, 32'd1);
    while (!norm_done && lat < 10) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check({tag, ".lat"}, lat, 32'd3);
    check({tag, ".res"}, norm_result, res);
    check({tag, ".flags"}, {30'b0, norm_overflow, norm_underflow}, {30'b0, ov, un});
    @(negedge clk);
    check({tag, ".done_drop"}, {31'b0, norm_done}, 32'd0);
  endtask

  initial begin
    int dones;

    // Reset state
    #12;
    check("rst.res", norm_result, 32'h0);
    check("rst.ctl", {28'b0, norm_busy, norm_done, norm_overflow, norm_underflow}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // Basic products
    run_op("v1.875",  1'b0, 10'd127, 48'h780000000000, 32'h3FF00000, 1'b0, 1'b0);
    run_op("v2.25",   1'b0, 10'd127, 48'h900000000000, 32'h40100000, 1'b0, 1'b0);
    run_op("v6.0",    1'b0, 10'd129, 48'h600000000000, 32'h40C00000, 1'b0, 1'b0);

    // Rounding
    run_op("tie_even", 1'b0, 10'd127, 48'h400000400000, 32'h3F800000, 1'b0, 1'b0);
    run_op("tie_odd",  1'b0, 10'd127, 48'h400000C00000, 32'h3F800002, 1'b0, 1'b0);
    run_op("rnd_cy",   1'b0, 10'd127, 48'h7FFFFFC00001, 32'h40000000, 1'b0, 1'b0);

    // Exponent boundaries
    run_op("max_norm", 1'b0, 10'd254, 48'h400000000000, 32'h7F000000, 1'b0, 1'b0);
    run_op("min_norm", 1'b0, 10'd1,   48'h400000000000, 32'h00800000, 1'b0, 1'b0);
    run_op("ovf",      1'b0, 10'd254, 48'h900000000000, 32'h7F800000, 1'b1, 1'b0);
    run_op("ovf_rnd",  1'b1, 10'd254, 48'h7FFFFFC00001, 32'hFF800000, 1'b1, 1'b0);
    run_op("unf",      1'b1, 10'd0,   48'h400000000000, 32'h80000000, 1'b0, 1'b1);
    run_op("unf_neg",  1'b0, 10'h3FB, 48'h600000000000, 32'h00000000, 1'b0, 1'b1);
    run_op("zero",     1'b1, 10'd127, 48'h000000000000, 32'h80000000, 1'b0, 1'b0);

    // Starts during NORM and ROUND are ignored
    @(negedge clk);
    raw_sign = 1'b0; raw_exp = 10'd127; raw_mant = 48'h780000000000; norm_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    raw_sign = 1'b1; raw_exp = 10'd200; raw_mant = 48'h900000000000;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) norm_start = 1'b0;
      if (norm_done) dones++;
    end
    check("hs.dones", dones, 32'd1);
    check("hs.res", norm_result, 32'h3FF00000);
    check("hs.idle", {31'b0, norm_busy}, 32'd0);

    // Leave overflow state visible, then reset during ROUND
    run_op("pre_rst", 1'b0, 10'd254, 48'h900000000000, 32'h7F800000, 1'b1, 1'b0);
    @(negedge clk);
    raw_sign = 1'b0; raw_exp = 10'd127; raw_mant = 48'h900000000000; norm_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    norm_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mrst.res", norm_result, 32'h0);
    check("mrst.ctl", {28'b0, norm_busy, norm_done, norm_overflow, norm_underflow}, 32'h0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (norm_done) dones++;
    end
    check("mrst.nodone", dones, 32'd0);
    n_rst = 1'b1;
    run_op("post_rst", 1'b0, 10'd127, 48'h900000000000, 32'h40100000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
